// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, HD44780 command codes and init ROM for lcd_ctrl
package lcd_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_PULSE     = 3'd2,
    S_HOLD      = 3'd3,
    S_WAIT      = 3'd4,
    S_INIT_WAIT = 3'd5
  } lcd_state_e;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
  localparam logic [7:0] LCD_INIT_ROM [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter that holds at zero and flags done there
module lcd_delay_cnt #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);
  logic [W-1:0] cnt;
  // load on phase entry, otherwise count down and park at zero
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) cnt <= RST_VAL;
    else if (i_load) cnt <= i_value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign o_done = (cnt == '0);
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns each LCD register write into one HD44780-timed bus cycle (optional LCD_INIT_SEQ_EN power-on init)
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2500,
  parameter int T_CLEAR_CYC = 82000,
  parameter int T_PWRON_CYC = 750000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_rs,
  input  logic [7:0] i_cmd_data,
  input  logic       i_lcd_on,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data,
  output logic       o_busy,
  output logic       o_init_done
);
  localparam int CW = $clog2(lcd_max(lcd_max(lcd_max(T_SETUP_CYC, T_EN_CYC), lcd_max(T_HOLD_CYC, T_EXEC_CYC)),
                                     lcd_max(T_CLEAR_CYC, T_PWRON_CYC))) + 1;
  if (T_SETUP_CYC < 1 || T_EN_CYC < 1 || T_HOLD_CYC < 1 || T_EXEC_CYC < 1 || T_CLEAR_CYC < 1 || T_PWRON_CYC < 1)
    begin : g_bad_timing
      $error("lcd_ctrl: all T_* timing parameters must be >= 1");
    end
`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e    S_RST   = S_INIT_WAIT;
  localparam logic [CW-1:0] CNT_RST = CW'(T_PWRON_CYC - 1);
  localparam logic          RDY_RST = 1'b0;
`else
  localparam lcd_state_e    S_RST   = S_IDLE;
  localparam logic [CW-1:0] CNT_RST = '0;
  localparam logic          RDY_RST = 1'b1;
`endif
  lcd_state_e    state, state_nx;
  logic          done, ld, clr, last, init_ld;
  logic [CW-1:0] ld_val;
  logic [7:0]    init_byte;
  assign clr      = ~o_lcd_rs & (o_lcd_data == LCD_CMD_CLEAR | o_lcd_data == LCD_CMD_HOME);
  assign o_lcd_rw = 1'b0;
  assign o_busy   = ~o_cmd_ready;
`ifdef LCD_INIT_SEQ_EN
  logic [1:0] idx;
  assign last      = o_init_done | (idx == 2'd3);
  assign init_ld   = done & (state == S_INIT_WAIT | (state == S_WAIT & ~last));
  assign init_byte = LCD_INIT_ROM[(state == S_INIT_WAIT) ? 2'd0 : idx + 2'd1];
  // step through the init ROM; done flag rises with the return to IDLE after the last entry
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      idx         <= '0;
      o_init_done <= 1'b0;
    end else if (state == S_WAIT && done && !o_init_done) begin
      idx         <= idx + 2'd1;
      o_init_done <= (idx == 2'd3);
    end
`else
  assign last        = 1'b1;
  assign init_ld     = 1'b0;
  assign init_byte   = '0;
  assign o_init_done = 1'b1;
`endif
  // phase sequencing: each phase ends when the shared delay counter reaches zero
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      state_nx = i_cmd_valid ? S_SETUP : S_IDLE;
      S_SETUP:     state_nx = done ? S_PULSE : S_SETUP;
      S_PULSE:     state_nx = done ? S_HOLD : S_PULSE;
      S_HOLD:      state_nx = done ? S_WAIT : S_HOLD;
      S_WAIT:      state_nx = done ? (last ? S_IDLE : S_SETUP) : S_WAIT;
      S_INIT_WAIT: state_nx = done ? S_SETUP : S_INIT_WAIT;
      default:     state_nx = S_IDLE;
    endcase
  end
  // reload the counter with N-1 of whichever phase is being entered
  always_comb begin
    ld     = (state_nx != state);
    ld_val = (state_nx == S_SETUP) ? CW'(T_SETUP_CYC - 1) :
             (state_nx == S_PULSE) ? CW'(T_EN_CYC - 1) :
             (state_nx == S_HOLD)  ? CW'(T_HOLD_CYC - 1) :
             clr                   ? CW'(T_CLEAR_CYC - 1) : CW'(T_EXEC_CYC - 1);
  end
  lcd_delay_cnt #(.W(CW), .RST_VAL(CNT_RST)) u_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (ld),
    .i_value (ld_val),
    .o_done  (done)
  );
  // state and bus outputs; rs/data only change when a command (user or init) is taken
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state       <= S_RST;
      o_lcd_en    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_data  <= '0;
      o_cmd_ready <= RDY_RST;
    end else begin
      state       <= state_nx;
      o_lcd_en    <= (state_nx == S_PULSE);
      o_cmd_ready <= (state_nx == S_IDLE);
      if (state == S_IDLE && i_cmd_valid) {o_lcd_rs, o_lcd_data} <= {i_cmd_rs, i_cmd_data};
      else if (init_ld) {o_lcd_rs, o_lcd_data} <= {1'b0, init_byte};
    end
  // power/backlight enable is a plain register, independent of the FSM
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) o_lcd_on <= 1'b0;
    else o_lcd_on <= i_lcd_on;
endmodule
